// File: rtl/mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mac_sequencer_pkg
// Shared types and helpers for the MAC sequencer slice.
//   seq_state_e : job sequencing states (IDLE, STREAM, DRAIN, FINISH)
//   is_last_f   : true when a zero-based counter sits on the last value of a
//                 range of length len (count == len-1)
// ---------------------------------------------------------------------------
package mac_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } seq_state_e;

   // Wide compare width so any counter/length width up to 32 bits can share
   // the helper after zero-extension.
   localparam int CMP_WIDTH = 32;

   // Last-beat compare: count is on the final position of a range of length len.
   function automatic logic is_last_f(input logic [CMP_WIDTH-1:0] count,
                                      input logic [CMP_WIDTH-1:0] len);
      return (count == (len - 32'd1));
   endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_sequencer_if
// Groups the job-config, operand, MAC-control and result handshakes of one
// MAC sequencer.
//   slave  modport : the sequencer itself
//   master modport : the environment (operand fetcher, MAC, result consumer)
// Signals:
//   cfg_valid_in/cfg_ready_out, cfg_k_len_in, cfg_n_out_in : job request
//   op_valid_in/op_ready_out                              : operand pair beat
//   mac_valid_out, mac_accum_out                          : MAC controls
//   res_valid_out/res_ready_in, res_index_out             : result handshake
//   done_out                                              : job finished pulse
// ---------------------------------------------------------------------------
interface mac_sequencer_if #(
   parameter int K_WIDTH = 16,
   parameter int N_WIDTH = 16
);
   logic               cfg_valid_in;
   logic               cfg_ready_out;
   logic [K_WIDTH-1:0] cfg_k_len_in;
   logic [N_WIDTH-1:0] cfg_n_out_in;
   logic               op_valid_in;
   logic               op_ready_out;
   logic               mac_valid_out;
   logic               mac_accum_out;
   logic               res_valid_out;
   logic               res_ready_in;
   logic [N_WIDTH-1:0] res_index_out;
   logic               done_out;

   modport slave (
      input  cfg_valid_in,
      input  cfg_k_len_in,
      input  cfg_n_out_in,
      input  op_valid_in,
      input  res_ready_in,
      output cfg_ready_out,
      output op_ready_out,
      output mac_valid_out,
      output mac_accum_out,
      output res_valid_out,
      output res_index_out,
      output done_out
   );

   modport master (
      output cfg_valid_in,
      output cfg_k_len_in,
      output cfg_n_out_in,
      output op_valid_in,
      output res_ready_in,
      input  cfg_ready_out,
      input  op_ready_out,
      input  mac_valid_out,
      input  mac_accum_out,
      input  res_valid_out,
      input  res_index_out,
      input  done_out
   );

endinterface

// File: rtl/mac_sequencer_wrap_counter.sv
// ---------------------------------------------------------------------------
// mac_sequencer_wrap_counter
// Zero-based counter over a range of length len: advances on en, returns to
// zero after the last value, and flags when it sits on the last value.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous return to zero (wins over en)
//   en       : advance one step
//   len      : range length (counter walks 0..len-1)
//   count    : current value
//   wrap     : count is on the last value (next en returns to zero)
// ---------------------------------------------------------------------------
module mac_sequencer_wrap_counter
   import mac_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] len,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] count_r;
   logic             wrap_s;

   // Last-value flag from the shared compare helper.
   always_comb begin
      wrap_s = is_last_f(CMP_WIDTH'(count_r), CMP_WIDTH'(len));
   end

   // Counter register: clear, then wrap-or-increment on enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WIDTH{1'b0}};
      end else if (en) begin
         if (wrap_s) begin
            count_r <= {WIDTH{1'b0}};
         end else begin
            count_r <= count_r + WIDTH'(1'b1);
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign wrap  = wrap_s;

endmodule

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
// Sequences one two-stage MAC (operand registers, then accumulator, both
// enabled by input_valid) through a job of N_OUT dot products of K_LEN
// operand pairs each. Because the MAC multiplies the operands latched on the
// previous pulse, every pulse adds the product of the previous operand pair;
// one extra pulse at the end of the job flushes the last pair.
// Ports:
//   clk      : clock
//   arst_in  : asynchronous reset, active-high
//   bus      : mac_sequencer_if.slave (config, operand, MAC, result, done)
// ---------------------------------------------------------------------------
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int K_WIDTH = 16,
   parameter int N_WIDTH = 16
) (
   input  logic           clk,
   input  logic           arst_in,
   mac_sequencer_if.slave bus
);

   seq_state_e         state_r;
   seq_state_e         state_s;

   logic [K_WIDTH-1:0] k_len_r;
   logic [N_WIDTH-1:0] n_out_r;
   logic [K_WIDTH-1:0] k_cnt_s;
   logic [N_WIDTH-1:0] o_cnt_s;
   logic               k_wrap_s;
   logic               o_wrap_s;

   logic [K_WIDTH-1:0] prev_k_r;
   logic [N_WIDTH-1:0] prev_o_r;
   logic               prev_valid_r;

   logic               res_valid_r;
   logic [N_WIDTH-1:0] res_index_r;

   logic               cfg_fire_s;
   logic               zero_job_s;
   logic               stall_s;
   logic               cfg_ready_s;
   logic               op_ready_s;
   logic               pulse_s;
   logic               stream_pulse_s;
   logic               o_en_s;
   logic               complete_s;
   logic               accum_s;
   logic               done_s;

   // Handshake qualifiers shared by the FSM and the datapath registers.
   always_comb begin
      cfg_fire_s = (state_r == IDLE) & bus.cfg_valid_in;
      zero_job_s = (bus.cfg_k_len_in == {K_WIDTH{1'b0}}) |
                   (bus.cfg_n_out_in == {N_WIDTH{1'b0}});
      // A held, unaccepted result sits in the MAC accumulator: no pulse may
      // disturb it.
      stall_s    = res_valid_r & ~bus.res_ready_in;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_s        = state_r;
      cfg_ready_s    = 1'b0;
      op_ready_s     = 1'b0;
      pulse_s        = 1'b0;
      stream_pulse_s = 1'b0;
      done_s         = 1'b0;
      case (state_r)
         IDLE: begin
            cfg_ready_s = 1'b1;
            if (bus.cfg_valid_in) begin
               if (zero_job_s) begin
                  state_s = FINISH;
               end else begin
                  state_s = STREAM;
               end
            end else begin
               state_s = IDLE;
            end
         end
         STREAM: begin
            op_ready_s     = ~stall_s;
            stream_pulse_s = bus.op_valid_in & ~stall_s;
            pulse_s        = stream_pulse_s;
            if (stream_pulse_s & k_wrap_s & o_wrap_s) begin
               state_s = DRAIN;
            end else begin
               state_s = STREAM;
            end
         end
         DRAIN: begin
            // Flush pulse: adds the last operand pair, operand inputs unused.
            pulse_s = ~stall_s;
            if (~stall_s) begin
               state_s = FINISH;
            end else begin
               state_s = DRAIN;
            end
         end
         FINISH: begin
            if (~res_valid_r) begin
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = FINISH;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // MAC control derived from the operand pair consumed on the previous pulse.
   always_comb begin
      // Previous operand was the first of its output: restart the sum.
      accum_s    = pulse_s & prev_valid_r & (prev_k_r != {K_WIDTH{1'b0}});
      // Previous operand was the last of its output: sum complete after this edge.
      complete_s = pulse_s & prev_valid_r &
                   is_last_f(CMP_WIDTH'(prev_k_r), CMP_WIDTH'(k_len_r));
      o_en_s     = stream_pulse_s & k_wrap_s;
   end

   // State register.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Job configuration latched on acceptance.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         k_len_r <= {K_WIDTH{1'b0}};
         n_out_r <= {N_WIDTH{1'b0}};
      end else if (cfg_fire_s) begin
         k_len_r <= bus.cfg_k_len_in;
         n_out_r <= bus.cfg_n_out_in;
      end else begin
         k_len_r <= k_len_r;
         n_out_r <= n_out_r;
      end
   end

   // Position of the operand pair now sitting in the MAC operand registers.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         prev_valid_r <= 1'b0;
         prev_k_r     <= {K_WIDTH{1'b0}};
         prev_o_r     <= {N_WIDTH{1'b0}};
      end else if (cfg_fire_s) begin
         prev_valid_r <= 1'b0;
         prev_k_r     <= {K_WIDTH{1'b0}};
         prev_o_r     <= {N_WIDTH{1'b0}};
      end else if (stream_pulse_s) begin
         prev_valid_r <= 1'b1;
         prev_k_r     <= k_cnt_s;
         prev_o_r     <= o_cnt_s;
      end else begin
         prev_valid_r <= prev_valid_r;
         prev_k_r     <= prev_k_r;
         prev_o_r     <= prev_o_r;
      end
   end

   // Result presentation: a completion pulse wins over an accept in the same
   // cycle, so back-to-back results keep valid high with the new index.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         res_valid_r <= 1'b0;
         res_index_r <= {N_WIDTH{1'b0}};
      end else if (complete_s) begin
         res_valid_r <= 1'b1;
         res_index_r <= prev_o_r;
      end else if (res_valid_r & bus.res_ready_in) begin
         res_valid_r <= 1'b0;
         res_index_r <= res_index_r;
      end else begin
         res_valid_r <= res_valid_r;
         res_index_r <= res_index_r;
      end
   end

   mac_sequencer_wrap_counter #(
      .WIDTH (K_WIDTH)
   ) u_k_cnt (
      .clk   (clk),
      .rst   (arst_in),
      .clear (cfg_fire_s),
      .en    (stream_pulse_s),
      .len   (k_len_r),
      .count (k_cnt_s),
      .wrap  (k_wrap_s)
   );

   mac_sequencer_wrap_counter #(
      .WIDTH (N_WIDTH)
   ) u_o_cnt (
      .clk   (clk),
      .rst   (arst_in),
      .clear (cfg_fire_s),
      .en    (o_en_s),
      .len   (n_out_r),
      .count (o_cnt_s),
      .wrap  (o_wrap_s)
   );

   assign bus.cfg_ready_out = cfg_ready_s;
   assign bus.op_ready_out  = op_ready_s;
   assign bus.mac_valid_out = pulse_s;
   assign bus.mac_accum_out = accum_s;
   assign bus.res_valid_out = res_valid_r;
   assign bus.res_index_out = res_index_r;
   assign bus.done_out      = done_s;

endmodule

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer
// Drives jobs into mac_sequencer with a behavioural two-stage MAC attached,
// and compares each accepted result against dot products computed directly
// from the generated operand lists.
// ---------------------------------------------------------------------------
module tb_mac_sequencer;

   localparam int KW     = 16;
   localparam int NW     = 16;
   localparam int BUDGET = 2000;

   logic clk = 1'b0;
   logic arst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mac_sequencer_if #(.K_WIDTH(KW), .N_WIDTH(NW)) bus ();

   mac_sequencer #(.K_WIDTH(KW), .N_WIDTH(NW)) dut (
      .clk     (clk),
      .arst_in (arst),
      .bus     (bus)
   );

   // Behavioural MAC: operand registers then accumulator, both on input_valid.
   logic [7:0]  op_a = 8'd0;
   logic [7:0]  op_b = 8'd0;
   logic [7:0]  mac_a_r = 8'd0;
   logic [7:0]  mac_b_r = 8'd0;
   logic [31:0] mac_acc_r = 32'd0;

   always @(posedge clk) begin
      if (bus.mac_valid_out) begin
         mac_a_r   <= op_a;
         mac_b_r   <= op_b;
         mac_acc_r <= (bus.mac_accum_out ? mac_acc_r : 32'd0) +
                      32'(mac_a_r) * 32'(mac_b_r);
      end
   end

   task automatic check_value(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_value({tag, "_cfg_ready"}, 64'(bus.cfg_ready_out), 64'd1);
      check_value({tag, "_op_ready"},  64'(bus.op_ready_out),  64'd0);
      check_value({tag, "_mac_valid"}, 64'(bus.mac_valid_out), 64'd0);
      check_value({tag, "_mac_accum"}, 64'(bus.mac_accum_out), 64'd0);
      check_value({tag, "_res_valid"}, 64'(bus.res_valid_out), 64'd0);
      check_value({tag, "_res_index"}, 64'(bus.res_index_out), 64'd0);
      check_value({tag, "_done"},      64'(bus.done_out),      64'd0);
   endtask

   // vmode: 0 random op_valid, 1 continuous, 2 alternating 1,0,1,0
   // op_mode: 0 random operands, 1 a=b=1, 2 a=i b=2
   // abort_beats > 0: assert reset after that many operand beats
   task automatic run_job(input int k, input int n, input int op_mode,
                          input int vmode, input int ready_pct,
                          input int hold_first, input bit mid_cfg,
                          input int abort_beats, input bit timing_chk);
      int a_q[$];
      int b_q[$];
      int exp_res[$];
      int first_beat_cyc[$];
      int total, s, cyc, pulses, beats, accepted, dones;
      int stall_viol, accum_err, stable_viol, lat_err, beat_viol, cfg_viol;
      int last_acc_cyc, held, extra_done, extra_mv, cfg_low;
      int idx, val, prev_idx, prev_val;
      bit cfg_acc, fin, prev_pending, beat, exp_accum, aborted, tog;
      total = k * n;
      cyc = 0; pulses = 0; beats = 0; accepted = 0; dones = 0;
      stall_viol = 0; accum_err = 0; stable_viol = 0; lat_err = 0;
      beat_viol = 0; cfg_viol = 0; last_acc_cyc = 0; held = 0;
      extra_done = 0; extra_mv = 0; cfg_low = 0;
      prev_idx = 0; prev_val = 0;
      cfg_acc = 1'b0; fin = 1'b0; prev_pending = 1'b0; aborted = 1'b0;
      tog = 1'b1;

      for (int i = 0; i < total; i++) begin
         case (op_mode)
            0: begin
               a_q.push_back(int'($urandom_range(0, 255)));
               b_q.push_back(int'($urandom_range(0, 255)));
            end
            1: begin
               a_q.push_back(1);
               b_q.push_back(1);
            end
            default: begin
               a_q.push_back(i % 256);
               b_q.push_back(2);
            end
         endcase
      end
      for (int j = 0; j < n && k > 0; j++) begin
         s = 0;
         for (int t = 0; t < k; t++) s += a_q[j*k+t] * b_q[j*k+t];
         exp_res.push_back(s);
      end

      bus.cfg_valid_in = 1'b1;
      bus.cfg_k_len_in = KW'(k);
      bus.cfg_n_out_in = NW'(n);
      bus.op_valid_in  = 1'b0;
      bus.res_ready_in = 1'b1;
      op_a = (a_q.size() > 0) ? 8'(a_q[0]) : 8'd0;
      op_b = (b_q.size() > 0) ? 8'(b_q[0]) : 8'd0;

      while (!fin && !aborted && cyc < BUDGET) begin
         @(negedge clk);
         if (cfg_acc && bus.cfg_ready_out) cfg_viol++;
         if (!cfg_acc && bus.cfg_valid_in && bus.cfg_ready_out) cfg_acc = 1'b1;
         if (bus.res_valid_out && !bus.res_ready_in &&
             (bus.mac_valid_out || bus.op_ready_out)) stall_viol++;
         if (bus.mac_valid_out) begin
            if (k > 0) begin
               exp_accum = (pulses > 0) && (((pulses - 1) % k) != 0);
               if (bus.mac_accum_out !== exp_accum) accum_err++;
            end
            pulses++;
         end
         beat = bus.op_valid_in && bus.op_ready_out;
         if (beat) begin
            if (!bus.mac_valid_out) beat_viol++;
            if (k > 0 && (beats % k) == 0) first_beat_cyc.push_back(cyc);
            beats++;
         end
         if (bus.res_valid_out) begin
            idx = int'(bus.res_index_out);
            val = int'(mac_acc_r);
            if (prev_pending) begin
               if (idx != prev_idx || val != prev_val) stable_viol++;
            end else if (timing_chk) begin
               if (idx < first_beat_cyc.size()) begin
                  if (cyc - first_beat_cyc[idx] != k + 1) lat_err++;
               end else begin
                  lat_err++;
               end
            end
            if (bus.res_ready_in) begin
               check_value("res_index", 64'(idx), 64'(accepted));
               if (accepted < exp_res.size())
                  check_value("res_value", 64'(val), 64'(exp_res[accepted]));
               else
                  check_value("res_extra", 64'(accepted), 64'(exp_res.size()));
               accepted++;
               last_acc_cyc = cyc;
            end
            prev_idx = idx;
            prev_val = val;
         end
         prev_pending = bus.res_valid_out && !bus.res_ready_in;
         if (bus.done_out) begin
            dones++;
            check_value("done_after_last_accept", 64'(accepted), 64'(exp_res.size()));
            if (total > 0)
               check_value("done_latency", 64'(cyc - last_acc_cyc), 64'd1);
            fin = 1'b1;
         end

         @(posedge clk);
         #1;
         cyc++;
         if (beat && a_q.size() > 0) begin
            void'(a_q.pop_front());
            void'(b_q.pop_front());
         end
         if (abort_beats > 0 && beats >= abort_beats) begin
            bus.cfg_valid_in = 1'b0;
            bus.op_valid_in  = 1'b0;
            arst = 1'b1;
            #1;
            check_idle_outputs("abort");
            @(negedge clk);
            arst = 1'b0;
            @(posedge clk);
            #1;
            aborted = 1'b1;
         end else begin
            if (fin) begin
               bus.cfg_valid_in = 1'b0;
            end else if (cfg_acc) begin
               bus.cfg_valid_in = mid_cfg ? 1'($urandom_range(0, 1)) : 1'b0;
               bus.cfg_k_len_in = KW'($urandom_range(0, 20));
               bus.cfg_n_out_in = NW'($urandom_range(0, 20));
            end
            tog = ~tog;
            if (fin) bus.op_valid_in = 1'b0;
            else if (a_q.size() > 0) begin
               case (vmode)
                  1:       bus.op_valid_in = 1'b1;
                  2:       bus.op_valid_in = tog;
                  default: bus.op_valid_in = ($urandom_range(0, 99) < 70);
               endcase
            end else begin
               bus.op_valid_in = (vmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            op_a = (a_q.size() > 0) ? 8'(a_q[0]) : 8'($urandom_range(0, 255));
            op_b = (b_q.size() > 0) ? 8'(b_q[0]) : 8'($urandom_range(0, 255));
            if (hold_first > 0 && accepted == 0 && bus.res_valid_out &&
                held < hold_first) begin
               bus.res_ready_in = 1'b0;
               held++;
            end else begin
               bus.res_ready_in = ($urandom_range(0, 99) < ready_pct);
            end
         end
      end

      if (!aborted) begin
         check_value("job_finished", 64'(fin), 64'd1);
         check_value("pulses", 64'(pulses), 64'((total > 0) ? total + 1 : 0));
         check_value("beats", 64'(beats), 64'(total));
         check_value("results", 64'(accepted), 64'(exp_res.size()));
         check_value("stall_viol", 64'(stall_viol), 64'd0);
         check_value("accum_err", 64'(accum_err), 64'd0);
         check_value("stable_viol", 64'(stable_viol), 64'd0);
         check_value("beat_viol", 64'(beat_viol), 64'd0);
         check_value("cfg_ready_busy", 64'(cfg_viol), 64'd0);
         if (timing_chk) check_value("latency_err", 64'(lat_err), 64'd0);
         bus.op_valid_in = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done_out) extra_done++;
            if (bus.mac_valid_out) extra_mv++;
            if (!bus.cfg_ready_out) cfg_low++;
            @(posedge clk);
            #1;
         end
         check_value("done_count", 64'(dones + extra_done), 64'd1);
         check_value("idle_mac_valid", 64'(extra_mv), 64'd0);
         check_value("idle_cfg_ready_low", 64'(cfg_low), 64'd0);
      end
      bus.cfg_valid_in = 1'b0;
      bus.op_valid_in  = 1'b0;
      bus.res_ready_in = 1'b1;
   endtask

   initial begin
      arst = 1'b1;
      bus.cfg_valid_in = 1'b0;
      bus.cfg_k_len_in = 16'd0;
      bus.cfg_n_out_in = 16'd0;
      bus.op_valid_in  = 1'b0;
      bus.res_ready_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_idle_outputs("reset");
      arst = 1'b0;
      @(posedge clk);
      #1;

      run_job(4, 2, 1, 1, 100, 0, 1'b0, 0, 1'b1);   // continuous, all ones
      run_job(1, 3, 2, 1, 100, 0, 1'b0, 0, 1'b1);   // K=1, results 0,2,4
      run_job(3, 2, 0, 1, 100, 5, 1'b0, 0, 1'b0);   // first result held 5 cycles
      run_job(2, 2, 0, 2, 100, 0, 1'b0, 0, 1'b0);   // alternating op_valid
      run_job(0, 5, 0, 1, 100, 0, 1'b1, 0, 1'b0);   // K=0
      run_job(3, 0, 0, 1, 100, 0, 1'b1, 0, 1'b0);   // N=0
      run_job(8, 4, 0, 1, 100, 0, 1'b0, 5, 1'b0);   // reset mid-stream
      check_idle_outputs("after_abort");
      run_job(3, 3, 0, 1, 100, 0, 1'b0, 0, 1'b1);   // clean job after reset
      for (int r = 0; r < 6; r++) begin
         run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                 0, 0, 60, 0, 1'b1, 0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
